// File: rtl/rv_pkg.sv
// Shared RV front-end types: data width, fetch FSM states, buffered instruction entry.
// Pure declarations; no timing or flow-control behaviour of its own.
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: imem request/response, decode-side instruction stream and redirect.
// master = fetch unit side; slave = memory/decode/branch side. Valid/ready on both streams.
interface fetch_unit_if;
  import rv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer of {instr, pc}; push visible at the head one cycle later (no bypass).
// No backpressure of its own: the caller's credit scheme keeps pushes within DEPTH; flush wins.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: nothing is read past the head while count is zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with redirect; response in cycle N reaches decode in N+1.
// Requests are credit-limited to FIFO_DEPTH (in flight + buffered); decode stalls via instr_ready.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 2;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   live;
  logic [CW-1:0]   stale;
  logic [CW-1:0]   fifo_count;
  logic [SW-1:0]   inflight;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            redir;
  logic            accept;
  logic            rsp_stale;
  logic            rsp_live;
  logic            push;
  logic            pop;
  logic [CW-1:0]   live_next;
  logic [CW-1:0]   stale_next;
  logic [CW-1:0]   stale_redir;
  logic [XLEN-1:0] rsp_pc;

  assign inflight = SW'(live) + SW'(stale) + SW'(fifo_count);
  assign bus.imem_req_valid = (state != ST_RESET) && (inflight < SW'(FIFO_DEPTH));
  assign bus.imem_req_addr  = pc;

  assign redir     = bus.redirect_valid && (state != ST_RESET);
  assign accept    = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_stale = bus.imem_rsp_valid && (stale != '0);
  assign rsp_live  = bus.imem_rsp_valid && (stale == '0);

  // Live requests are always consecutive words ending just below pc, so the
  // oldest one (the one answering now) sits live words back.
  assign rsp_pc     = pc - XLEN'({live, 2'b00});
  assign push_entry = '{instr: bus.imem_rsp_data, pc: rsp_pc};
  assign push       = rsp_live && !redir;
  assign pop        = bus.instr_valid && bus.instr_ready && !redir;

  assign live_next   = live + CW'(accept) - CW'(rsp_live);
  assign stale_next  = stale - CW'(rsp_stale);
  assign stale_redir = stale + live + CW'(accept) - CW'(bus.imem_rsp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RESET;
      pc    <= RESET_PC;
      live  <= '0;
      stale <= '0;
    end else begin
      case (state)
        ST_RESET: state <= ST_FETCH;
        default: begin
          if (redir) begin
            pc    <= align_word(bus.redirect_pc);
            live  <= '0;
            stale <= stale_redir;
            state <= (stale_redir != '0) ? ST_FLUSH : ST_FETCH;
          end else begin
            if (accept) pc <= pc + 32'd4;
            live  <= live_next;
            stale <= stale_next;
            if (state == ST_FLUSH && stale_next == '0) state <= ST_FETCH;
          end
        end
      endcase
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redir),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count)
  );

  assign bus.instr_valid = (fifo_count != '0);
  assign bus.instr       = bus.instr_valid ? head.instr : '0;
  assign bus.instr_pc    = bus.instr_valid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, then randomized traffic against a queue-based model.
module tb_fetch_unit;
  import rv_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: outstanding requests in order, each tagged stale or not.
  typedef struct { logic [31:0] pc; bit stale; } oreq_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  oreq_t        oq[$];
  fetch_entry_t fq[$];
  mreq_t        mq[$];
  logic [31:0]  m_pc;
  bit           m_started;
  int           cyc;

  logic        s_rv, s_iv;
  logic [31:0] s_ra, s_i, s_ipc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive_idle();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_instr_pc", bus.instr_pc, 32'd0);
    drive_idle();
    oq.delete();
    fq.delete();
    mq.delete();
    m_pc      = RPC;
    m_started = 1'b0;
    cyc       = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rv_before_first_edge", 32'(bus.imem_req_valid), 32'd0);
    @(posedge clk);
    m_started = 1'b1;
    #1;
  endtask

  task automatic model_cycle(input logic rr, input logic ir, input logic rd, input logic [31:0] rpc);
    logic        e_rv, e_iv, acc_m, acc_d, pop_m, rsp;
    logic [31:0] rdata;
    oreq_t       r;
    bus.imem_req_ready = rr;
    bus.instr_ready    = ir;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    rsp   = (mq.size() > 0) && (mq[0].due <= cyc);
    rdata = rsp ? mem_word(mq[0].addr) : $urandom;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rdata;
    e_rv = m_started && ((oq.size() + fq.size()) < DEPTH);
    e_iv = fq.size() > 0;
    @(negedge clk);
    s_rv  = bus.imem_req_valid;
    s_ra  = bus.imem_req_addr;
    s_iv  = bus.instr_valid;
    s_i   = bus.instr;
    s_ipc = bus.instr_pc;
    chk("req_valid", 32'(s_rv), 32'(e_rv));
    if (e_rv) chk("req_addr", s_ra, m_pc);
    chk("instr_valid", 32'(s_iv), 32'(e_iv));
    if (e_iv) begin
      chk("instr", s_i, fq[0].instr);
      chk("instr_pc", s_ipc, fq[0].pc);
    end
    acc_m = e_rv && rr;
    acc_d = s_rv && rr;
    pop_m = e_iv && ir && !rd;
    @(posedge clk);
    cyc++;
    if (rsp) void'(mq.pop_front());
    if (acc_d) mq.push_back('{addr: s_ra, due: cyc + int'($urandom_range(0, 2))});
    if (pop_m) void'(fq.pop_front());
    if (rsp && oq.size() > 0) begin
      r = oq.pop_front();
      if (!r.stale && !rd) fq.push_back('{instr: rdata, pc: r.pc});
    end
    if (acc_m) oq.push_back('{pc: m_pc, stale: rd});
    if (rd) begin
      foreach (oq[k]) oq[k].stale = 1'b1;
      fq.delete();
      m_pc = rpc & ~32'd3;
    end else if (acc_m) begin
      m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  // Directed vectors: memory response driven explicitly, data = A000_0000 | address.
  typedef struct {
    logic rr; logic rsv; logic [31:0] raddr; logic ir; logic rd; logic [31:0] rpc;
    logic rv; logic [31:0] ra; logic iv; logic [31:0] ipc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rr, input logic rsv, input logic [31:0] raddr,
                              input logic ir, input logic rd, input logic [31:0] rpc,
                              input logic rv, input logic [31:0] ra, input logic iv,
                              input logic [31:0] ipc);
    vec_t v;
    v.rr = rr; v.rsv = rsv; v.raddr = raddr; v.ir = ir; v.rd = rd; v.rpc = rpc;
    v.rv = rv; v.ra = ra; v.iv = iv; v.ipc = ipc;
    return v;
  endfunction

  initial begin
    int  accepted;
    bit  found;
    drive_idle();
    //           rr rsv raddr      ir rd rpc        rv ra         iv ipc
    tbl.push_back(mk(1, 0, 32'h000, 1, 0, 32'h000, 1, 32'h000, 0, 32'h000));
    tbl.push_back(mk(1, 1, 32'h000, 1, 0, 32'h000, 1, 32'h004, 0, 32'h000));
    tbl.push_back(mk(1, 1, 32'h004, 1, 0, 32'h000, 0, 32'h008, 1, 32'h000));
    tbl.push_back(mk(1, 0, 32'h000, 1, 0, 32'h000, 1, 32'h008, 1, 32'h004));
    tbl.push_back(mk(1, 1, 32'h008, 0, 0, 32'h000, 1, 32'h00C, 0, 32'h000));
    tbl.push_back(mk(1, 1, 32'h00C, 0, 0, 32'h000, 0, 32'h010, 1, 32'h008));
    tbl.push_back(mk(1, 0, 32'h000, 0, 0, 32'h000, 0, 32'h010, 1, 32'h008));
    tbl.push_back(mk(1, 0, 32'h000, 1, 0, 32'h000, 0, 32'h010, 1, 32'h008));
    tbl.push_back(mk(1, 0, 32'h000, 0, 0, 32'h000, 1, 32'h010, 1, 32'h00C));
    tbl.push_back(mk(1, 0, 32'h000, 1, 0, 32'h000, 0, 32'h014, 1, 32'h00C));
    tbl.push_back(mk(1, 0, 32'h000, 1, 0, 32'h000, 1, 32'h014, 0, 32'h000));
    tbl.push_back(mk(1, 0, 32'h000, 1, 1, 32'h100, 0, 32'h018, 0, 32'h000));
    tbl.push_back(mk(1, 1, 32'h010, 1, 0, 32'h000, 0, 32'h100, 0, 32'h000));
    tbl.push_back(mk(1, 1, 32'h014, 1, 0, 32'h000, 1, 32'h100, 0, 32'h000));
    tbl.push_back(mk(1, 1, 32'h100, 0, 0, 32'h000, 1, 32'h104, 0, 32'h000));
    tbl.push_back(mk(1, 1, 32'h104, 1, 1, 32'h203, 0, 32'h108, 1, 32'h100));
    tbl.push_back(mk(0, 0, 32'h000, 1, 0, 32'h000, 1, 32'h200, 0, 32'h000));
    tbl.push_back(mk(0, 0, 32'h000, 1, 0, 32'h000, 1, 32'h200, 0, 32'h000));
    tbl.push_back(mk(1, 0, 32'h000, 1, 0, 32'h000, 1, 32'h200, 0, 32'h000));
    tbl.push_back(mk(1, 1, 32'h200, 1, 0, 32'h000, 1, 32'h204, 0, 32'h000));
    tbl.push_back(mk(1, 1, 32'h204, 1, 0, 32'h000, 0, 32'h208, 1, 32'h200));
    tbl.push_back(mk(0, 0, 32'h000, 1, 0, 32'h000, 1, 32'h208, 1, 32'h204));

    #1 do_reset();

    foreach (tbl[n]) begin
      bus.imem_req_ready = tbl[n].rr;
      bus.imem_rsp_valid = tbl[n].rsv;
      bus.imem_rsp_data  = tbl[n].rsv ? (32'hA000_0000 | tbl[n].raddr) : 32'h0;
      bus.instr_ready    = tbl[n].ir;
      bus.redirect_valid = tbl[n].rd;
      bus.redirect_pc    = tbl[n].rpc;
      @(negedge clk);
      chk($sformatf("t%0d_req_valid", n), 32'(bus.imem_req_valid), 32'(tbl[n].rv));
      if (tbl[n].rv) chk($sformatf("t%0d_req_addr", n), bus.imem_req_addr, tbl[n].ra);
      chk($sformatf("t%0d_instr_valid", n), 32'(bus.instr_valid), 32'(tbl[n].iv));
      if (tbl[n].iv) begin
        chk($sformatf("t%0d_instr", n), bus.instr, 32'hA000_0000 | tbl[n].ipc);
        chk($sformatf("t%0d_instr_pc", n), bus.instr_pc, tbl[n].ipc);
      end
      @(posedge clk);
      #1;
    end

    // Address hold under imem backpressure, then 32-bit PC wrap.
    do_reset();
    model_cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    for (int k = 0; k < 5; k++) begin
      model_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      chk("hold_valid", 32'(s_rv), 32'd1);
      chk("hold_addr", s_ra, 32'hFFFF_FFFC);
    end
    model_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    model_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr", s_ra, 32'h0000_0000);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      model_cycle(1'b0, 1'b1, 1'b0, 32'h0);
      if (s_iv) begin
        found = 1'b1;
        chk("wrap_instr_pc", s_ipc, 32'hFFFF_FFFC);
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wrap_timeout: instr_valid never rose, required within 10 cycles");
    end

    // Decode stall: issue stays within the credit, nothing lost afterwards.
    accepted = 0;
    for (int k = 0; k < 10; k++) begin
      model_cycle(1'b1, 1'b0, 1'b0, 32'h0);
      if (s_rv) accepted++;
    end
    chk("stall_credit_ok", 32'(accepted <= DEPTH), 32'd1);
    for (int k = 0; k < 10; k++) model_cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomized traffic with redirects, including same-cycle accept/push/pop.
    for (int k = 0; k < 2500; k++) begin
      model_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 11) == 0), $urandom);
    end

    // Reset mid-stream with traffic in flight, then restart from RESET_PC.
    for (int k = 0; k < 3; k++) model_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    do_reset();
    model_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("restart_valid", 32'(s_rv), 32'd1);
    chk("restart_addr", s_ra, RPC);
    for (int k = 0; k < 40; k++) begin
      model_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1) != 0),
                  1'($urandom_range(0, 15) == 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2: instruction buffer entries; this is also the maximum in-flight requests.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port imem_req_valid, output, 1: fetch request valid.
REQ-006 Port imem_req_ready, input, 1: memory accepts the request this cycle.
REQ-007 Port imem_req_addr, output, 32: word-aligned fetch address.
REQ-008 Port imem_rsp_valid, input, 1: instruction word returned; responses arrive in request order, latency ≥1.
REQ-009 Port imem_rsp_data, input, 32: returned instruction word.
REQ-010 Port instr_valid, output, 1: buffered instruction available to decode.
REQ-011 Port instr_ready, input, 1: decode consumes the instruction this cycle.
REQ-012 Port instr, output, 32: instruction word for the decoder.
REQ-013 Port instr_pc, output, 32: address of instr.
REQ-014 Port redirect_valid, input, 1: branch/jal/jalr redirect.
REQ-015 Port redirect_pc, input, 32: redirect target.

Function
REQ-016 Request handshake: request accepted when imem_req_valid && imem_req_ready; imem_req_addr stable while valid and not accepted.
REQ-017 imem_req_valid = (live_outstanding + stale_outstanding + fifo_count < FIFO_DEPTH), so the FIFO never overflows.
REQ-018 On acceptance with no redirect: fetch PC <= PC + 4, 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-019 Each response pushes {data, pc} into the FIFO unless stale_outstanding > 0; stale responses are dropped and decrement stale_outstanding.
REQ-020 Output handshake: pop when instr_valid && instr_ready; instr/instr_pc = FIFO head, registered; response in cycle N -> instr_valid in cycle N+1 (no bypass).
REQ-021 Simultaneous push and pop: count unchanged, order preserved.
REQ-022 Redirect (cycle R): FIFO flushed; live_outstanding moved into stale_outstanding; PC <= {redirect_pc[31:2], 2'b00}; instr_valid = 0 in cycle R+1.
REQ-023 A request accepted in cycle R is counted stale; the next request uses the redirect target.
REQ-024 Redirect beats a same-cycle pop (pop ignored) and a same-cycle push (data dropped).
REQ-025 State machine:
- RESET -> FETCH on the first edge after rst_n deasserts.
- FETCH -> FLUSH when redirect_valid and any request is outstanding.
- FLUSH -> FETCH when stale_outstanding reaches 0.
- New requests may issue in FLUSH under REQ-017.
REQ-026 Back-to-back redirects: each redirect adds all remaining live requests to stale; the latest target wins.

Reset
REQ-027 While rst_n = 0:
- imem_req_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0.
- PC = RESET_PC; FIFO empty; both outstanding counters = 0; state RESET.
REQ-028 Reset mid-operation discards all buffered and in-flight data; the memory is reset on the same rst_n.
REQ-029 imem_req_valid rises in the first cycle after the first clock edge following deassertion.

Structure
REQ-030 Shared package rv_pkg: XLEN = 32, the fetch state enum, and the default RESET_PC constant.
REQ-031 One sub-module, fetch_fifo: parameterised depth; push, pop, and flush inputs; count output; stores {instr, pc}.

Verification
REQ-032 Reset release, mem latency 1, instr_ready = 1: requests to 0x0, 0x4, 0x8…; instr_pc sequence matches; one instruction per cycle in steady state.
REQ-033 instr_ready = 0 for 10 cycles: at most 2 outstanding plus buffered; no request beyond the FIFO_DEPTH credit; no data lost when ready returns.
REQ-034 Redirect to 0x100 with 2 requests in flight: both responses dropped; next instr_pc = 0x100; instr_valid = 0 in cycle R+1.
REQ-035 Redirect to 0x203: aligned to 0x200; same-cycle pop and push are ignored/dropped.
REQ-036 imem_req_ready low for 5 cycles: imem_req_addr holds; PC wraps 0xFFFFFFFC -> 0x0.
REQ-037 rst_n asserted mid-stream: all outputs go to zero asynchronously; restart fetches from RESET_PC.
